// File: rtl/seqdet_pkg.sv
// seqdet_pkg: shared constants and helpers for the parametrised sequence
// detector (seq_detector_param) and its window sub-module.
//   PAT_W_DEF / CNT_W_DEF / PAT_RST_DEF : default parameter values
//   fill_w()                            : width of the fill counter, clog2(PAT_W+1)
package seqdet_pkg;

    localparam int PAT_W_DEF = 4;
    localparam int CNT_W_DEF = 8;
    localparam logic [PAT_W_DEF-1:0] PAT_RST_DEF = 4'b1011;

    // fill counts 0..PAT_W inclusive, hence PAT_W+1 distinct values.
    function automatic int fill_w(input int pat_w);
        return $clog2(pat_w + 1);
    endfunction

endpackage

// File: rtl/seq_detector_param_if.sv
// seq_detector_param_if: serial-stream and status bundle of the detector.
//   master modport (stimulus side): drives x, valid, load, pattern_in, overlap;
//                                   observes F, match_count, fill.
//   slave modport  (detector side): the reverse.
// Signals:
//   x           serial data bit
//   valid       x is sampled only when valid=1
//   load        latch pattern_in and restart detection
//   pattern_in  new pattern, bit PAT_W-1 is the first bit received
//   overlap     1=overlapping detection, 0=non-overlapping
//   F           registered one-cycle match pulse
//   match_count saturating match counter
//   fill        number of valid history bits, 0..PAT_W
interface seq_detector_param_if
    import seqdet_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEF,
    parameter int CNT_W = CNT_W_DEF
);

    localparam int FILL_W = fill_w(PAT_W);

    logic              x;
    logic              valid;
    logic              load;
    logic [PAT_W-1:0]  pattern_in;
    logic              overlap;
    logic              F;
    logic [CNT_W-1:0]  match_count;
    logic [FILL_W-1:0] fill;

    modport master (
        output x, valid, load, pattern_in, overlap,
        input  F, match_count, fill
    );

    modport slave (
        input  x, valid, load, pattern_in, overlap,
        output F, match_count, fill
    );

endinterface

// File: rtl/seqdet_window.sv
// seqdet_window: serial history shift register plus fill counter.
// Ports:
//   clk, rst  clock and synchronous active-high reset
//   clr       synchronous clear of history and fill (load / non-overlap match)
//   shift     accept bit_in on this edge
//   bit_in    serial data bit
//   hist_nxt  window as it would be after shifting bit_in in (newest at LSB)
//   fill      registered count of valid history bits, 0..PAT_W
//   fill_nxt  fill as it would be after accepting bit_in (saturates at PAT_W)
module seqdet_window
    import seqdet_pkg::*;
#(
    parameter  int PAT_W  = PAT_W_DEF,
    localparam int FILL_W = fill_w(PAT_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              shift,
    input  logic              bit_in,
    output logic [PAT_W-1:0]  hist_nxt,
    output logic [FILL_W-1:0] fill,
    output logic [FILL_W-1:0] fill_nxt
);

    // Only the PAT_W-1 newest bits ever reach a compare: the incoming bit
    // completes the window, so the oldest stored bit would always be shifted
    // out before it is looked at.
    logic [PAT_W-2:0]  hist_q;
    logic [FILL_W-1:0] fill_q;

    assign hist_nxt = {hist_q, bit_in};
    assign fill_nxt = (fill_q == FILL_W'(PAT_W)) ? fill_q : fill_q + 1'b1;
    assign fill     = fill_q;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            hist_q <= '0;
            fill_q <= '0;
        end else if (shift) begin
            hist_q <= hist_nxt[PAT_W-2:0];
            fill_q <= fill_nxt;
        end
    end

endmodule

// File: rtl/seq_detector_param.sv
// seq_detector_param: parametrised serial sequence detector.
// Samples one bit of bus.x per edge with bus.valid=1 and compares the last
// PAT_W accepted bits against a run-time loadable pattern. Emits a registered
// one-cycle pulse bus.F per match and keeps a saturating match counter.
// Ports:
//   clk  clock, rising edge
//   rst  synchronous active-high reset (pattern <= PAT_RST, all else cleared)
//   bus  seq_detector_param_if.slave (x, valid, load, pattern_in, overlap in;
//        F, match_count, fill out)
// Edge priority: rst > load > valid.
// Build option: define SEQDET_CLR_ON_LOAD_EN to have load also clear
// match_count; by default only rst clears it.
module seq_detector_param
    import seqdet_pkg::*;
#(
    parameter int               PAT_W   = PAT_W_DEF,
    parameter int               CNT_W   = CNT_W_DEF,
    parameter logic [PAT_W-1:0] PAT_RST = PAT_W'(PAT_RST_DEF)
) (
    input logic                 clk,
    input logic                 rst,
    seq_detector_param_if.slave bus
);

    localparam int FILL_W = fill_w(PAT_W);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic [PAT_W-1:0]  pattern_q;
    logic [PAT_W-1:0]  hist_nxt;
    logic [FILL_W-1:0] fill_q;
    logic [FILL_W-1:0] fill_nxt;
    logic              accept;
    logic              hit;
    logic              win_clr;
    logic              f_p1;
    logic [CNT_W-1:0]  cnt_p1;

    // load wins over valid: the bit presented with a load is discarded.
    assign accept = bus.valid & ~bus.load;
    assign hit    = accept && (fill_nxt == FILL_W'(PAT_W)) && (hist_nxt == pattern_q);
    // Non-overlapping mode restarts the window after every match.
    assign win_clr = bus.load | (hit & ~bus.overlap);

    seqdet_window #(
        .PAT_W (PAT_W)
    ) u_window (
        .clk      (clk),
        .rst      (rst),
        .clr      (win_clr),
        .shift    (accept),
        .bit_in   (bus.x),
        .hist_nxt (hist_nxt),
        .fill     (fill_q),
        .fill_nxt (fill_nxt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            pattern_q <= PAT_RST;
        end else if (bus.load) begin
            pattern_q <= bus.pattern_in;
        end
    end

    // ---- stage p1: registered match pulse and counter ----
    always_ff @(posedge clk) begin
        if (rst) begin
            f_p1 <= 1'b0;
        end else begin
            f_p1 <= hit;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_p1 <= '0;
`ifdef SEQDET_CLR_ON_LOAD_EN
        end else if (bus.load) begin
            cnt_p1 <= '0;
`endif
        end else if (hit) begin
            cnt_p1 <= sat_inc(cnt_p1);
        end
    end

    assign bus.F           = f_p1;
    assign bus.match_count = cnt_p1;
    assign bus.fill        = fill_q;

endmodule
